// File: rtl/issue_unit.sv
// Instruction queue plus in-order issue: decodes the head, renames rd, and dispatches to RS or SLB one cycle after the issuing edge.
// Head issues only when ROB and target station are ready; if_ready_out drops when the queue is full.
module issue_unit #(
  parameter int Q_WIDTH        = 5,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int IQ_DEPTH       = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic                      flush_in,
  input  logic                      if_valid_in,
  input  logic [31:0]               if_instr_in,
  input  logic [31:0]               if_pc_in,
  output logic                      if_ready_out,
  output logic [REG_ADDR_WIDTH-1:0] rs1_out,
  output logic [REG_ADDR_WIDTH-1:0] rs2_out,
  input  logic [31:0]               V1_in,
  input  logic [31:0]               V2_in,
  input  logic [Q_WIDTH-1:0]        Q1_in,
  input  logic [Q_WIDTH-1:0]        Q2_in,
  input  logic                      cdb_valid_in,
  input  logic [Q_WIDTH-1:0]        cdb_tag_in,
  input  logic [31:0]               cdb_value_in,
  input  logic                      rob_ready_in,
  input  logic [Q_WIDTH-1:0]        rob_tag_in,
  output logic                      rob_alloc_out,
  output logic [REG_ADDR_WIDTH-1:0] rd_out,
  output logic                      rd_we_out,
  input  logic                      rs_ready_in,
  input  logic                      slb_ready_in,
  output logic                      rs_valid_out,
  output logic                      slb_valid_out,
  output logic [6:0]                opcode_out,
  output logic [2:0]                func3_out,
  output logic [6:0]                func7_out,
  output logic [31:0]               V1_out,
  output logic [31:0]               V2_out,
  output logic [Q_WIDTH-1:0]        Q1_out,
  output logic [Q_WIDTH-1:0]        Q2_out,
  output logic [31:0]               imm_out,
  output logic [31:0]               pc_out,
  output logic [Q_WIDTH-1:0]        dest_out
);
  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(IQ_DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [63:0]      mem [IQ_DEPTH];
  logic [PTR_W-1:0] head_ptr, tail_ptr;
  logic [CNT_W-1:0] count;

  logic [31:0] hi;
  logic [31:0] head_pc;
  logic [6:0]  opc;
  logic [4:0]  rs1_f, rs2_f, rd_f;
  logic        head_vld, known, use1, use2, wr_rd, is_mem;
  logic [31:0] imm;
  logic        tgt_rdy, issue, pop, enq;
  logic [31:0] v1, v2;
  logic [Q_WIDTH-1:0] q1, q2;

  assign hi      = mem[head_ptr][63:32];
  assign head_pc = mem[head_ptr][31:0];
  assign opc     = hi[6:0];
  assign rd_f    = hi[11:7];
  assign rs1_f   = hi[19:15];
  assign rs2_f   = hi[24:20];

  assign rs1_out = REG_ADDR_WIDTH'(rs1_f);
  assign rs2_out = REG_ADDR_WIDTH'(rs2_f);
  assign rd_out  = REG_ADDR_WIDTH'(rd_f);

  always_comb begin
    known  = 1'b0;
    use1   = 1'b0;
    use2   = 1'b0;
    wr_rd  = 1'b0;
    is_mem = 1'b0;
    imm    = 32'h0;
    case (opc)
      OPC_OP: begin
        known = 1'b1; use1 = 1'b1; use2 = 1'b1; wr_rd = 1'b1;
      end
      OPC_OPIMM, OPC_JALR, OPC_LOAD: begin
        known = 1'b1; use1 = 1'b1; wr_rd = 1'b1; is_mem = (opc == OPC_LOAD);
        imm = {{20{hi[31]}}, hi[31:20]};
      end
      OPC_STORE: begin
        known = 1'b1; use1 = 1'b1; use2 = 1'b1; is_mem = 1'b1;
        imm = {{20{hi[31]}}, hi[31:25], hi[11:7]};
      end
      OPC_BRANCH: begin
        known = 1'b1; use1 = 1'b1; use2 = 1'b1;
        imm = {{19{hi[31]}}, hi[31], hi[7], hi[30:25], hi[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        known = 1'b1; wr_rd = 1'b1;
        imm = {hi[31:12], 12'h0};
      end
      OPC_JAL: begin
        known = 1'b1; wr_rd = 1'b1;
        imm = {{11{hi[31]}}, hi[31], hi[19:12], hi[20], hi[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  // Operand select: unused or x0 reads as ready zero, otherwise catch a same-cycle CDB broadcast.
  always_comb begin
    v1 = V1_in;
    q1 = Q1_in;
    if (!use1 || rs1_f == 5'd0) begin
      v1 = 32'h0;
      q1 = '0;
    end else if (Q1_in != '0 && cdb_valid_in && cdb_tag_in == Q1_in) begin
      v1 = cdb_value_in;
      q1 = '0;
    end
    v2 = V2_in;
    q2 = Q2_in;
    if (!use2 || rs2_f == 5'd0) begin
      v2 = 32'h0;
      q2 = '0;
    end else if (Q2_in != '0 && cdb_valid_in && cdb_tag_in == Q2_in) begin
      v2 = cdb_value_in;
      q2 = '0;
    end
  end

  assign head_vld      = (count != '0);
  assign tgt_rdy       = is_mem ? slb_ready_in : rs_ready_in;
  assign issue         = head_vld & rdy_in & ~flush_in & known & rob_ready_in & tgt_rdy;
  // Unknown opcodes are dropped so they cannot wedge the queue.
  assign pop           = head_vld & rdy_in & ~flush_in & (issue | ~known);
  assign if_ready_out  = (count < FULL_CNT);
  assign enq           = if_valid_in & if_ready_out & rdy_in & ~flush_in;
  assign rob_alloc_out = issue;
  assign rd_we_out     = issue & wr_rd & (rd_f != 5'd0);

  always_ff @(posedge clk_in) begin
    if (enq) mem[tail_ptr] <= {if_instr_in, if_pc_in};
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush_in) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (enq) tail_ptr <= tail_ptr + 1'b1;
      if (pop) head_ptr <= head_ptr + 1'b1;
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rs_valid_out  <= 1'b0;
      slb_valid_out <= 1'b0;
      opcode_out    <= '0;
      func3_out     <= '0;
      func7_out     <= '0;
      V1_out        <= '0;
      V2_out        <= '0;
      Q1_out        <= '0;
      Q2_out        <= '0;
      imm_out       <= '0;
      pc_out        <= '0;
      dest_out      <= '0;
    end else begin
      rs_valid_out  <= issue & ~is_mem;
      slb_valid_out <= issue & is_mem;
      if (issue) begin
        opcode_out <= opc;
        func3_out  <= hi[14:12];
        func7_out  <= hi[31:25];
        V1_out     <= v1;
        V2_out     <= v2;
        Q1_out     <= q1;
        Q2_out     <= q2;
        imm_out    <= imm;
        pc_out     <= head_pc;
        dest_out   <= rob_tag_in;
      end
    end
  end
endmodule

// File: tb/tb_issue_unit.sv
// Randomized and directed bench for issue_unit against a queue-based reference model.
module tb_issue_unit;
  localparam int QW = 5;
  localparam int RW = 5;
  localparam int DEPTH = 8;
  localparam int K_NONE = 0, K_R = 1, K_I = 2, K_S = 3, K_B = 4, K_U = 5, K_J = 6;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b1;
  logic rdy_in = 1'b0, flush_in = 1'b0, if_valid_in = 1'b0;
  logic [31:0] if_instr_in = '0, if_pc_in = '0;
  logic if_ready_out;
  logic [RW-1:0] rs1_out, rs2_out, rd_out;
  logic [31:0] V1_in = '0, V2_in = '0;
  logic [QW-1:0] Q1_in = '0, Q2_in = '0;
  logic cdb_valid_in = 1'b0;
  logic [QW-1:0] cdb_tag_in = '0;
  logic [31:0] cdb_value_in = '0;
  logic rob_ready_in = 1'b0;
  logic [QW-1:0] rob_tag_in = '0;
  logic rob_alloc_out, rd_we_out;
  logic rs_ready_in = 1'b0, slb_ready_in = 1'b0;
  logic rs_valid_out, slb_valid_out;
  logic [6:0] opcode_out, func7_out;
  logic [2:0] func3_out;
  logic [31:0] V1_out, V2_out, imm_out, pc_out;
  logic [QW-1:0] Q1_out, Q2_out, dest_out;

  issue_unit #(.Q_WIDTH(QW), .REG_ADDR_WIDTH(RW), .IQ_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .if_valid_in(if_valid_in), .if_instr_in(if_instr_in), .if_pc_in(if_pc_in),
    .if_ready_out(if_ready_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
    .V1_in(V1_in), .V2_in(V2_in), .Q1_in(Q1_in), .Q2_in(Q2_in),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_value_in(cdb_value_in),
    .rob_ready_in(rob_ready_in), .rob_tag_in(rob_tag_in), .rob_alloc_out(rob_alloc_out),
    .rd_out(rd_out), .rd_we_out(rd_we_out), .rs_ready_in(rs_ready_in),
    .slb_ready_in(slb_ready_in), .rs_valid_out(rs_valid_out), .slb_valid_out(slb_valid_out),
    .opcode_out(opcode_out), .func3_out(func3_out), .func7_out(func7_out),
    .V1_out(V1_out), .V2_out(V2_out), .Q1_out(Q1_out), .Q2_out(Q2_out),
    .imm_out(imm_out), .pc_out(pc_out), .dest_out(dest_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: queued {instr, pc} and the expected dispatch registers.
  logic [63:0] mq[$];
  bit e_rs_v, e_slb_v;
  logic [6:0] e_op, e_f7;
  logic [2:0] e_f3;
  logic [31:0] e_v1, e_v2, e_imm, e_pc;
  logic [QW-1:0] e_q1, e_q2, e_dest;

  function automatic int kind_of(input logic [6:0] op);
    case (op)
      7'b0110011: return K_R;
      7'b0010011, 7'b0000011, 7'b1100111: return K_I;
      7'b0100011: return K_S;
      7'b1100011: return K_B;
      7'b0110111, 7'b0010111: return K_U;
      7'b1101111: return K_J;
      default: return K_NONE;
    endcase
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] ins, input int k);
    int s;
    s = int'($signed(ins));
    case (k)
      K_I: return 32'(s >>> 20);
      K_S: return 32'(((s >>> 25) << 5) | int'(ins[11:7]));
      K_B: return 32'(((s >>> 31) << 12) | (int'(ins[7]) << 11) | (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1));
      K_U: return ins & 32'hFFFF_F000;
      K_J: return 32'(((s >>> 31) << 20) | (int'(ins[19:12]) << 12) | (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1));
      default: return 32'h0;
    endcase
  endfunction

  task automatic operand(input bit used, input logic [4:0] idx, input logic [31:0] v,
                         input logic [QW-1:0] q, output logic [31:0] ov, output logic [QW-1:0] oq);
    if (!used || idx == 0) begin
      ov = 0; oq = 0;
    end else if (q != 0 && cdb_valid_in && cdb_tag_in == q) begin
      ov = cdb_value_in; oq = 0;
    end else begin
      ov = v; oq = q;
    end
  endtask

  // One clock: inputs were set at the preceding falling edge.
  task automatic tick();
    logic [31:0] hi;
    logic [6:0] op;
    int k;
    bit hv, full_ok, mem, iss, pop, enq;
    #1;
    hv = mq.size() > 0;
    full_ok = mq.size() < DEPTH;
    hi = hv ? mq[0][63:32] : 32'h0;
    op = hi[6:0];
    k = hv ? kind_of(op) : K_NONE;
    mem = (op == 7'b0000011) || (op == 7'b0100011);
    iss = hv && k != K_NONE && rdy_in && !flush_in && rob_ready_in && (mem ? slb_ready_in : rs_ready_in);
    check("if_ready", 32'(if_ready_out), 32'(full_ok));
    check("rob_alloc", 32'(rob_alloc_out), 32'(iss));
    check("rd_we", 32'(rd_we_out), 32'(iss && hi[11:7] != 0 && k != K_S && k != K_B));
    if (hv) begin
      check("rs1", 32'(rs1_out), 32'(hi[19:15]));
      check("rs2", 32'(rs2_out), 32'(hi[24:20]));
      check("rd", 32'(rd_out), 32'(hi[11:7]));
    end
    pop = hv && rdy_in && !flush_in && (iss || k == K_NONE);
    enq = if_valid_in && full_ok && rdy_in && !flush_in;
    e_rs_v = iss && !mem;
    e_slb_v = iss && mem;
    if (iss) begin
      e_op = op; e_f3 = hi[14:12]; e_f7 = hi[31:25];
      e_imm = imm_of(hi, k);
      e_pc = mq[0][31:0];
      e_dest = rob_tag_in;
      operand(k == K_R || k == K_I || k == K_S || k == K_B, hi[19:15], V1_in, Q1_in, e_v1, e_q1);
      operand(k == K_R || k == K_S || k == K_B, hi[24:20], V2_in, Q2_in, e_v2, e_q2);
    end
    if (flush_in) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (enq) mq.push_back({if_instr_in, if_pc_in});
    end
    @(posedge clk_in);
    @(negedge clk_in);
    check("rs_valid", 32'(rs_valid_out), 32'(e_rs_v));
    check("slb_valid", 32'(slb_valid_out), 32'(e_slb_v));
    if (e_rs_v || e_slb_v) begin
      check("opcode", 32'(opcode_out), 32'(e_op));
      check("func3", 32'(func3_out), 32'(e_f3));
      check("func7", 32'(func7_out), 32'(e_f7));
      check("V1", V1_out, e_v1);
      check("V2", V2_out, e_v2);
      check("Q1", 32'(Q1_out), 32'(e_q1));
      check("Q2", 32'(Q2_out), 32'(e_q2));
      check("imm", imm_out, e_imm);
      check("pc", pc_out, e_pc);
      check("dest", 32'(dest_out), 32'(e_dest));
    end
  endtask

  task automatic all_ready();
    rdy_in = 1; flush_in = 0; if_valid_in = 0; rob_ready_in = 1;
    rs_ready_in = 1; slb_ready_in = 1; cdb_valid_in = 0;
    V1_in = 0; V2_in = 0; Q1_in = 0; Q2_in = 0;
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    if_valid_in = 1; if_instr_in = ins; if_pc_in = pc;
    tick();
    if_valid_in = 0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_rs_valid"}, 32'(rs_valid_out), 32'h0);
    check({tag, "_slb_valid"}, 32'(slb_valid_out), 32'h0);
    check({tag, "_if_ready"}, 32'(if_ready_out), 32'h1);
    check({tag, "_rob_alloc"}, 32'(rob_alloc_out), 32'h0);
    check({tag, "_opcode"}, 32'(opcode_out), 32'h0);
    check({tag, "_V1"}, V1_out, 32'h0);
    check({tag, "_imm"}, imm_out, 32'h0);
    check({tag, "_dest"}, 32'(dest_out), 32'h0);
  endtask

  task automatic model_reset();
    mq.delete();
    e_rs_v = 0; e_slb_v = 0;
  endtask

  logic [6:0] op_tab[11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                              7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0001111, 7'b1110011};

  initial begin
    logic [31:0] r;
    #2 rst_n_in = 0;
    #1 reset_checks("por");
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1;
    model_reset();
    all_ready();
    tick();

    // ADDI x1,x0,5 dispatches one cycle after issue with dest = ROB tag.
    rob_tag_in = 5'd7;
    push(32'h0050_0093, 32'h0000_0100);
    tick();
    check("addi_rs_valid", 32'(rs_valid_out), 32'h1);
    check("addi_imm", imm_out, 32'h5);
    check("addi_V1", V1_out, 32'h0);
    check("addi_Q1", 32'(Q1_out), 32'h0);
    check("addi_dest", 32'(dest_out), 32'h7);

    // LW blocked by the SLB for three cycles.
    slb_ready_in = 0;
    rob_tag_in = 5'd9;
    push(32'h0040_a103, 32'h0000_0104);
    repeat (3) tick();
    slb_ready_in = 1;
    tick();
    check("lw_slb_valid", 32'(slb_valid_out), 32'h1);
    check("lw_imm", imm_out, 32'h4);
    tick();

    // Fill to capacity, reject the extra push, then drain in order.
    rs_ready_in = 0;
    for (int i = 0; i < DEPTH; i++) push(32'h0000_0093 | (32'(i + 1) << 20), 32'h200 + 32'(i * 4));
    #1 check("full_if_ready", 32'(if_ready_out), 32'h0);
    push(32'h0630_0093, 32'h0000_0300);
    rs_ready_in = 1;
    for (int i = 0; i < DEPTH + 2; i++) tick();

    // CDB bypass on rs1 at issue.
    V1_in = 32'h1111; V2_in = 32'h22;
    push(32'h0020_81b3, 32'h0000_0400);
    Q1_in = 5'd3; cdb_valid_in = 1; cdb_tag_in = 5'd3; cdb_value_in = 32'hDEAD_BEEF;
    tick();
    check("cdb_V1", V1_out, 32'hDEAD_BEEF);
    check("cdb_Q1", 32'(Q1_out), 32'h0);
    all_ready();

    // Flush with four queued entries and a simultaneous push.
    rs_ready_in = 0;
    for (int i = 0; i < 4; i++) push(32'h0010_0093, 32'h500 + 32'(i * 4));
    flush_in = 1;
    push(32'h0020_0113, 32'h0000_0600);
    flush_in = 0; rs_ready_in = 1;
    tick();
    check("flush_no_dispatch", 32'(rs_valid_out), 32'h0);
    tick();

    // Asynchronous reset while a dispatch is visible and entries are queued.
    rs_ready_in = 0;
    for (int i = 0; i < 3; i++) push(32'h0010_0093, 32'h700 + 32'(i * 4));
    rs_ready_in = 1;
    tick();
    #2 rst_n_in = 0;
    #1 reset_checks("mid");
    model_reset();
    @(negedge clk_in);
    rst_n_in = 1;
    all_ready();
    tick();
    tick();

    for (int c = 0; c < 600; c++) begin
      r = $urandom;
      if_instr_in = {r[31:7], op_tab[$urandom_range(0, 10)]};
      if_pc_in = $urandom & 32'hFFFF_FFFC;
      if_valid_in = ($urandom_range(0, 9) < 6);
      rdy_in = ($urandom_range(0, 9) != 0);
      flush_in = ($urandom_range(0, 24) == 0);
      rob_ready_in = ($urandom_range(0, 9) < 8);
      rs_ready_in = ($urandom_range(0, 3) != 0);
      slb_ready_in = ($urandom_range(0, 3) != 0);
      rob_tag_in = QW'($urandom);
      V1_in = $urandom; V2_in = $urandom;
      Q1_in = $urandom_range(0, 1) ? '0 : QW'($urandom);
      Q2_in = $urandom_range(0, 1) ? '0 : QW'($urandom);
      cdb_valid_in = $urandom_range(0, 1);
      cdb_tag_in = ($urandom_range(0, 2) == 0) ? Q1_in : (($urandom_range(0, 1) == 0) ? Q2_in : QW'($urandom));
      cdb_value_in = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
